// File: rtl/buzz_pkg.sv
// Shared types and helpers for the buzzer scheduler.
package buzz_pkg;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned BEAT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } prio_t;

    // Highest set bit wins; vld low when no bit is set.
    function automatic prio_t prio_enc(input logic [NREQ-1:0] v);
        prio_t r;
        r.vld = 1'b0;
        r.id  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (v[i]) begin
                r.vld = 1'b1;
                r.id  = ID_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/buzzer_scheduler_beat_tick.sv
// Beat prescaler: counts 0..DIV-1, tick_c high on the terminal count, clr restarts at 0.
module beat_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count decode.
    always_comb begin
        tick_c = (cnt_q == CNT_W'(DIV - 1));
    end

    // Next count: restart on clear or wrap, otherwise advance.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick_c) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buzzer_scheduler.sv
// Buzzer scheduler: shares one buzzer among four tone sources by fixed priority
// (source 3 highest), playing each for its beat count followed by a silent gap.
// Optional macro BUZZ_PREEMPT_EN: a higher-priority request aborts the current tone.
module buzzer_scheduler
    import buzz_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BEAT_HZ   = 4,
    parameter int unsigned DUR0      = 2,
    parameter int unsigned DUR1      = 2,
    parameter int unsigned DUR2      = 8,
    parameter int unsigned DUR3      = 64,
    parameter int unsigned GAP_BEATS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] audio_in,
    output logic [NREQ-1:0] en,
    output logic            audio,
    output logic            busy,
    output logic [ID_W-1:0] cur_id,
    output logic            done
);

    localparam int unsigned DIV = CLK_HZ / BEAT_HZ;

    state_e            state_q;
    state_e            state_d;
    logic [ID_W-1:0]   cur_id_q;
    logic [ID_W-1:0]   cur_id_d;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [BEAT_W-1:0] beat_cnt_d;
    logic [NREQ-1:0]   pend_q;
    logic [NREQ-1:0]   pend_d;

    prio_t win;
    logic  tick_c;
    logic  clr_c;
    logic  grant_c;
    logic  done_c;
    logic  preempt_c;

    // Play length of a source in beats.
    function automatic logic [BEAT_W-1:0] dur_of(input logic [ID_W-1:0] id);
        logic [BEAT_W-1:0] d;
        case (id)
            2'd0:    d = BEAT_W'(DUR0);
            2'd1:    d = BEAT_W'(DUR1);
            2'd2:    d = BEAT_W'(DUR2);
            default: d = BEAT_W'(DUR3);
        endcase
        return d;
    endfunction

    // Candidate for the next grant among latched and fresh requests.
    always_comb begin
        win = prio_enc(pend_q | req);
    end

`ifdef BUZZ_PREEMPT_EN
    // A strictly higher-priority candidate aborts the tone in progress.
    always_comb begin
        preempt_c = win.vld && (win.id > cur_id_q);
    end
`else
    // Tones always run to completion.
    always_comb begin
        preempt_c = 1'b0;
    end
`endif

    // Next-state, beat counter, grant and prescaler restart.
    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        beat_cnt_d = beat_cnt_q;
        grant_c    = 1'b0;
        clr_c      = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                clr_c = 1'b1;
                if (win.vld) begin
                    grant_c = 1'b1;
                end
            end
            PLAY: begin
                if (preempt_c) begin
                    grant_c = 1'b1;
                end else if (tick_c) begin
                    if (beat_cnt_q == BEAT_W'(1)) begin
                        done_c = 1'b1;
                        if (GAP_BEATS != 0) begin
                            state_d    = GAP;
                            beat_cnt_d = BEAT_W'(GAP_BEATS);
                            clr_c      = 1'b1;
                        end else if (win.vld) begin
                            grant_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                            clr_c   = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick_c) begin
                    if (beat_cnt_q == BEAT_W'(1)) begin
                        if (win.vld) begin
                            grant_c = 1'b1;
                        end else begin
                            state_d = IDLE;
                            clr_c   = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q - BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                clr_c   = 1'b1;
            end
        endcase

        if (grant_c) begin
            state_d    = PLAY;
            cur_id_d   = win.id;
            beat_cnt_d = dur_of(win.id);
            clr_c      = 1'b1;
        end
    end

    // Pending latch: a grant consumes the winner's latched request; a fresh
    // request arriving alongside an already latched one survives and replays.
    always_comb begin
        pend_d = pend_q | req;
        if (grant_c) begin
            pend_d[win.id] = pend_q[win.id] & req[win.id];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_id_q   <= '0;
            beat_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            beat_cnt_q <= beat_cnt_d;
            pend_q     <= pend_d;
        end
    end

    // Output decode from registered state; audio muxes the granted player.
    always_comb begin
        en     = '0;
        audio  = 1'b0;
        busy   = (state_q != IDLE);
        cur_id = cur_id_q;
        done   = done_c;
        if (state_q == PLAY) begin
            en[cur_id_q] = 1'b1;
            audio        = audio_in[cur_id_q];
        end
    end

    beat_tick #(
        .DIV(DIV)
    ) u_beat_tick (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_c),
        .tick_c(tick_c)
    );

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench for buzzer_scheduler (DIV=10, DUR=2/2/8/64).
module tb_buzzer_scheduler;

    localparam int unsigned DIV = 10;
`ifdef BUZZ_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    int unsigned dur_beats [4] = '{2, 2, 8, 64};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ain;
    logic [3:0] req_g0;
    logic [3:0] en, en_g0;
    logic       audio, audio_g0;
    logic       busy, busy_g0;
    logic [1:0] cur_id, cur_id_g0;
    logic       done, done_g0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    buzzer_scheduler #(
        .CLK_HZ(40), .BEAT_HZ(4), .DUR0(2), .DUR1(2), .DUR2(8), .DUR3(64), .GAP_BEATS(1)
    ) u_dut (
        .clk(clk), .rst(rst), .req(req), .audio_in(ain),
        .en(en), .audio(audio), .busy(busy), .cur_id(cur_id), .done(done)
    );

    buzzer_scheduler #(
        .CLK_HZ(40), .BEAT_HZ(4), .DUR0(2), .DUR1(2), .DUR2(8), .DUR3(64), .GAP_BEATS(0)
    ) u_dut_g0 (
        .clk(clk), .rst(rst), .req(req_g0), .audio_in(ain),
        .en(en_g0), .audio(audio_g0), .busy(busy_g0), .cur_id(cur_id_g0), .done(done_g0)
    );

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  a;
        int unsigned n;
        logic [3:0]  x_en;
        logic        x_busy;
        logic        x_done;
        logic [1:0]  x_cur;
        logic        x_audio;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic mk(input logic [3:0] r, input logic [3:0] a, input int unsigned n,
                      input logic [3:0] e, input logic b, input logic d,
                      input logic [1:0] c, input logic au);
        vec_t v;
        v.r = r; v.a = a; v.n = n; v.x_en = e; v.x_busy = b;
        v.x_done = d; v.x_cur = c; v.x_audio = au;
        vecs.push_back(v);
    endtask

    // Inputs are driven just after the rising edge; outputs sampled at the falling edge.
    task automatic apply(input logic [3:0] r, input logic [3:0] a);
        req = r;
        ain = a;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ain = '0;
        req_g0 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: phase with a remaining-cycle countdown.
    int         m_phase;   // 0 idle, 1 play, 2 gap
    int         m_rem;
    int         m_id;
    logic [3:0] m_pend;

    function automatic int highest(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit m_preempt(input logic [3:0] r);
        int w;
        w = highest(m_pend | r);
        return PREEMPT && (m_phase == 1) && (w > m_id);
    endfunction

    task automatic m_step(input logic [3:0] r);
        logic [3:0] old;
        int         w;
        bit         g;
        old = m_pend;
        w   = highest(m_pend | r);
        g   = 1'b0;
        if (m_phase == 0) begin
            g = (w >= 0);
        end else if (m_phase == 1) begin
            if (m_preempt(r)) g = 1'b1;
            else if (m_rem == 1) begin
                m_phase = 2;
                m_rem   = int'(DIV);
            end else m_rem--;
        end else begin
            if (m_rem == 1) begin
                if (w >= 0) g = 1'b1;
                else m_phase = 0;
            end else m_rem--;
        end
        m_pend = old | r;
        if (g) begin
            m_phase   = 1;
            m_id      = w;
            m_rem     = int'(dur_beats[w] * DIV);
            m_pend[w] = old[w] & r[w];
        end
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] a;
        logic [3:0] xe;
        int         nd;

        do_reset();

        // Reset state.
        apply(4'b0000, 4'b1111);
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cur", 32'(cur_id), 32'h0);
        chk("rst_audio", 32'(audio), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        advance();

        // Single req[0]: 20 play cycles, 10 gap cycles, idle.
        mk(4'b0001, 4'b0000, 1,  4'b0000, 0, 0, 2'd0, 0);
        mk(4'b0000, 4'b0001, 19, 4'b0001, 1, 0, 2'd0, 1);
        mk(4'b0000, 4'b0000, 1,  4'b0001, 1, 1, 2'd0, 0);
        mk(4'b0000, 4'b1111, 10, 4'b0000, 1, 0, 2'd0, 0);
        mk(4'b0000, 4'b1111, 2,  4'b0000, 0, 0, 2'd0, 0);
        // req[1] and req[2] together: source 2 first, then source 1.
        mk(4'b0110, 4'b0000, 1,  4'b0000, 0, 0, 2'd0, 0);
        mk(4'b0000, 4'b0100, 79, 4'b0100, 1, 0, 2'd2, 1);
        mk(4'b0000, 4'b0100, 1,  4'b0100, 1, 1, 2'd2, 1);
        mk(4'b0000, 4'b0000, 10, 4'b0000, 1, 0, 2'd2, 0);
        mk(4'b0000, 4'b1101, 19, 4'b0010, 1, 0, 2'd1, 0);
        mk(4'b0000, 4'b0010, 1,  4'b0010, 1, 1, 2'd1, 1);
        mk(4'b0000, 4'b0000, 10, 4'b0000, 1, 0, 2'd1, 0);
        mk(4'b0000, 4'b0000, 2,  4'b0000, 0, 0, 2'd1, 0);
        // req[2] held 3 cycles during its own tone: one replay after the gap.
        mk(4'b0100, 4'b0000, 1,  4'b0000, 0, 0, 2'd1, 0);
        mk(4'b0000, 4'b0100, 5,  4'b0100, 1, 0, 2'd2, 1);
        mk(4'b0100, 4'b0100, 3,  4'b0100, 1, 0, 2'd2, 1);
        mk(4'b0000, 4'b1011, 71, 4'b0100, 1, 0, 2'd2, 0);
        mk(4'b0000, 4'b0100, 1,  4'b0100, 1, 1, 2'd2, 1);
        mk(4'b0000, 4'b0000, 10, 4'b0000, 1, 0, 2'd2, 0);
        mk(4'b0000, 4'b0100, 79, 4'b0100, 1, 0, 2'd2, 1);
        mk(4'b0000, 4'b0000, 1,  4'b0100, 1, 1, 2'd2, 0);
        mk(4'b0000, 4'b0000, 10, 4'b0000, 1, 0, 2'd2, 0);
        mk(4'b0000, 4'b0000, 2,  4'b0000, 0, 0, 2'd2, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                apply(vecs[i].r, vecs[i].a);
                chk($sformatf("vec%0d_en", i),    32'(en),     32'(vecs[i].x_en));
                chk($sformatf("vec%0d_busy", i),  32'(busy),   32'(vecs[i].x_busy));
                chk($sformatf("vec%0d_done", i),  32'(done),   32'(vecs[i].x_done));
                chk($sformatf("vec%0d_cur", i),   32'(cur_id), 32'(vecs[i].x_cur));
                chk($sformatf("vec%0d_audio", i), 32'(audio),  32'(vecs[i].x_audio));
                advance();
            end
        end

`ifdef BUZZ_PREEMPT_EN
        // req[3] during source-0 tone: switch next cycle, no done for source 0.
        apply(4'b0001, 4'b0000);
        advance();
        for (int k = 0; k <= 660; k++) begin
            r = (k == 5) ? 4'b1000 : 4'b0000;
            apply(r, 4'b0000);
            xe = (k <= 5) ? 4'b0001 : (k <= 645) ? 4'b1000 : 4'b0000;
            chk("pre_en", 32'(en), 32'(xe));
            chk("pre_done", 32'(done), 32'(k == 645));
            advance();
        end
`else
        // req[0] during source-3 tone: waits for 640 play cycles plus the gap.
        apply(4'b1000, 4'b0000);
        advance();
        for (int k = 0; k < 675; k++) begin
            r = (k == 5) ? 4'b0001 : 4'b0000;
            apply(r, 4'b0000);
            xe = (k < 640) ? 4'b1000 : (k < 650) ? 4'b0000 : (k < 670) ? 4'b0001 : 4'b0000;
            chk("prio_en", 32'(en), 32'(xe));
            chk("prio_done", 32'(done), 32'((k == 639) || (k == 669)));
            advance();
        end
`endif

        // No gap: source 1 then source 0 back to back.
        req_g0 = 4'b0011;
        @(negedge clk);
        chk("g0_idle_en", 32'(en_g0), 32'h0);
        advance();
        req_g0 = 4'b0000;
        nd = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            xe = (k < 20) ? 4'b0010 : (k < 40) ? 4'b0001 : 4'b0000;
            chk("g0_en", 32'(en_g0), 32'(xe));
            chk("g0_busy", 32'(busy_g0), 32'(k < 40));
            chk("g0_done", 32'(done_g0), 32'((k == 19) || (k == 39)));
            if (done_g0) nd++;
            advance();
        end
        chk("g0_done_count", 32'(nd), 32'd2);

        // Asynchronous reset mid-tone with requests pending.
        apply(4'b0100, 4'b0000);
        advance();
        apply(4'b0011, 4'b1111);
        advance();
        for (int k = 0; k < 30; k++) begin
            apply(4'b0000, 4'b1111);
            advance();
        end
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_audio", 32'(audio), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en", 32'(en), 32'h0);
        chk("arst_audio", 32'(audio), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_cur", 32'(cur_id), 32'h0);
        advance();
        rst = 1'b0;
        for (int k = 0; k < 120; k++) begin
            apply(4'b0000, 4'b1111);
            chk("post_rst_busy", 32'(busy), 32'h0);
            chk("post_rst_en", 32'(en), 32'h0);
            advance();
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_phase = 0; m_rem = 0; m_id = 0; m_pend = '0;
        for (int c = 0; c < 5000; c++) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 79) == 0);
            a = 4'($urandom);
            apply(r, a);
            xe = (m_phase == 1) ? (4'b0001 << m_id) : 4'b0000;
            chk("rnd_en", 32'(en), 32'(xe));
            chk("rnd_busy", 32'(busy), 32'(m_phase != 0));
            chk("rnd_cur", 32'(cur_id), 32'(m_id));
            chk("rnd_audio", 32'(audio), 32'((m_phase == 1) && a[m_id]));
            chk("rnd_done", 32'(done), 32'((m_phase == 1) && (m_rem == 1) && !m_preempt(r)));
            m_step(r);
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
